// File: rtl/gcd_core.sv
// Iterative subtractive-Euclid GCD engine: one operation in flight, result held until next completion.
// Optional CALC-cycle counter output enabled by defining GCD_CYCLE_COUNT_EN.
module gcd_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] r_out
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [31:0]           cycles
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] a_nxt;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] b_nxt;
    logic [DATA_WIDTH-1:0] r_nxt;
    logic                  done_nxt;

`ifdef GCD_CYCLE_COUNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_nxt;
    logic [31:0] cycles_nxt;
    logic [31:0] cnt_inc;

    // Saturating increment so a runaway operation never wraps the count.
    assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
`endif

    assign ready = (state == IDLE);
    assign busy  = ~ready;

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        r_nxt     = r_out;
        done_nxt  = 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
        cnt_nxt    = cnt_q;
        cycles_nxt = cycles;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = a_in;
                    b_nxt     = b_in;
                    state_nxt = CALC;
`ifdef GCD_CYCLE_COUNT_EN
                    cnt_nxt   = 32'd0;
`endif
                end
            end
            CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
                cnt_nxt = cnt_inc;
`endif
                // Zero checks come first so a zero operand never reaches the subtract path.
                if (a_q == '0) begin
                    r_nxt     = b_q;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (b_q == '0 || a_q == b_q) begin
                    r_nxt     = a_q;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (a_q > b_q) begin
                    a_nxt = a_q - b_q;
                end else begin
                    b_nxt = b_q - a_q;
                end
`ifdef GCD_CYCLE_COUNT_EN
                if (done_nxt) begin
                    cycles_nxt = cnt_inc;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            r_out <= '0;
            done  <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
            cnt_q  <= 32'd0;
            cycles <= 32'd0;
`endif
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            r_out <= r_nxt;
            done  <= done_nxt;
`ifdef GCD_CYCLE_COUNT_EN
            cnt_q  <= cnt_nxt;
            cycles <= cycles_nxt;
`endif
        end
    end

endmodule

// File: doc/gcd_core.md
Name: gcd_core

Overview:
- Iterative subtractive-Euclid GCD engine. It sits directly downstream of the DAQ AXI4-Lite register block.
- The register block drives a_in (from reg 0x04), b_in (from reg 0x08) and a start pulse (from a write of 1 to reg 0x00).
- The register block reads r_out back through reg 0x0C and polls ready/done.
- One operation in flight at a time. Operands are captured on start, and the result is held until the next completion.

Parameters:
DATA_WIDTH, 32, width of operands and result (unsigned)

Ports:
aclk     input   1           system clock; all logic on rising edge
areset   input   1           synchronous, active-high reset
start    input   1           request; sampled only while ready=1
a_in     input   DATA_WIDTH  operand A, captured on accepted start
b_in     input   DATA_WIDTH  operand B, captured on accepted start
ready    output  1           1 = IDLE, start will be accepted
busy     output  1           1 = CALC in progress (always ~ready)
done     output  1           one-cycle pulse when r_out is updated
r_out    output  DATA_WIDTH  last result; held until next completion

Behaviour:
- Clock/reset: one clock (aclk). Reset is synchronous and active-high (areset).
- Reset values: state=IDLE, ready=1, busy=0, done=0, r_out=0; internal a/b registers=0.
- areset has priority over all other logic, including mid-CALC. An operation in flight is abandoned, with no done pulse and r_out=0.
- States: IDLE, CALC.
- IDLE:
  - On an edge with start=1: a<=a_in, b<=b_in, go to CALC; ready/busy flip on that edge.
  - start=0: remain in IDLE.
- CALC, one decision per edge, evaluated in this priority order:
  1. a==0 -> r_out<=b, done<=1, go to IDLE.
  2. b==0 -> r_out<=a, done<=1, go to IDLE.
  3. a==b -> r_out<=a, done<=1, go to IDLE.
  4. a>b -> a<=a-b.
  5. else -> b<=b-a.
- Arithmetic: unsigned, DATA_WIDTH-bit compare/subtract. The subtract only occurs when minuend > subtrahend, so no underflow is possible. No carry bit is needed.
- Latency: with N subtractions, done is high N+1 cycles after the start-accept edge. Examples:
  - gcd(35,25): N=4, latency 5.
  - gcd(128,72): N=6, latency 7.
  - Worst case gcd(2^W-1, 1): N=2^W-2. Software must poll ready; no timeout.
- done:
  - Pulses exactly one cycle, on the same edge that ready returns to 1.
  - Deasserts on the following edge regardless of start.
- Back-to-back: start may be high in the cycle done=1 (state is IDLE), which launches the next op immediately.
- start while busy: ignored, not queued. a_in/b_in changes while busy have no effect.
- Zero operands:
  - gcd(0,x)=x and gcd(x,0)=x, each with latency 1.
  - gcd(0,0)=0, latency 1, done still pulses.
- r_out changes only on a done edge or on reset.

Optional Feature:
- Macro: GCD_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycles [31:0]; reset value 0.
  - An internal counter clears on start-accept and increments on every CALC edge.
  - On the done edge, cycles<=counter+1, i.e. the total CALC cycles of the operation; held until the next done.
  - The counter saturates at 2^32-1.
  - The register block maps cycles to read address 0x10.
- Not defined:
  - No cycles port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset: hold areset=1 for 5 cycles, release -> ready=1, busy=0, done=0, r_out=0; start held low gives no state change for 10 cycles.
- gcd(35,25): start for one cycle with a_in=35, b_in=25 -> busy for 5 cycles, done pulse 1 cycle, r_out=5, ready=1 on the done cycle; cycles=5 with GCD_CYCLE_COUNT_EN.
- gcd(128,72) issued with start high in the done cycle of the previous op -> accepted immediately; done after 7 cycles, r_out=8; cycles=7 with macro.
- Zero cases: (0,9)->r_out=9, (9,0)->r_out=9, (0,0)->r_out=0, each done 1 cycle after accept.
- Ignore while busy: start gcd(1000,1) (N=999), pulse start with (6,4) at cycle 10 -> ignored; done at cycle 1000, r_out=1; no second done follows.
- Reset mid-op: start gcd(1000,1), assert areset at cycle 20 -> next edge ready=1, r_out=0, no done pulse; a following gcd(12,18) returns r_out=6 after 3 cycles.
